motor_step_sequencer: RTL and testbench

- Parametrised next-generation commutation step generator for multi-phase PWM motor drive.
- Generalises the 3-phase, 12-step, fixed-period sequencer to N phases and M steps, with a runtime speed ramp (freqInc/freqDec), reverse direction and a force-stop state.
- Sits between the register block (period, split and ramp settings) and the per-phase PWM drivers.
- Each phase receives a 4-bit step index; the drivers also use the split sub-step, first/last-of-step strobes and pwmActive.

---
 rtl/motor_step_sequencer.sv | 127 ++++++++++++
 tb/tb_motor_step_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/motor_step_sequencer.sv
// motor_step_sequencer: N-phase, M-step commutation sequencer with a period ramp and force-stop.
// Define MOTOR_STEP_DIR_REV_EN to honour dirRev (reverse step order); otherwise the order is always forward.
module motor_step_sequencer #(
  parameter int CNT_W      = 25,
  parameter int SPLIT_W    = 2,
  parameter int PHASES     = 3,
  parameter int STEPS      = 12,
  parameter int ROUND_W    = 48,
  parameter int MIN_PERIOD = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stopReq,
  input  logic                  dirRev,
  input  logic [CNT_W-1:0]      periodSet,
  input  logic [CNT_W-1:0]      periodStep,
  input  logic [SPLIT_W-1:0]    splitMax,
  input  logic                  freqInc,
  input  logic                  freqDec,
  output logic [PHASES*4-1:0]   stepVec,
  output logic                  pwmActive,
  output logic [SPLIT_W-1:0]    splitStep,
  output logic [CNT_W-1:0]      cnt,
  output logic                  cntFirst,
  output logic                  cntLast,
  output logic                  stepTick,
  output logic [CNT_W-1:0]      periodCur,
  output logic [ROUND_W-1:0]    roundCnt,
  output logic [1:0]            state
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2} state_t;
  localparam int SEG = STEPS / PHASES;
  localparam logic [3:0] LAST = 4'(STEPS - 1);
  localparam logic [3:0] STEPS4 = 4'(STEPS);
  localparam logic [CNT_W-1:0] MINP = CNT_W'(MIN_PERIOD);
  state_t r_state;
  logic r_start_d1, r_first, r_pwm;
  logic [3:0] r_step0;
  logic [CNT_W-1:0] r_cnt, r_period;
  logic [SPLIT_W-1:0] r_split;
  logic [ROUND_W-1:0] r_round;
  logic [CNT_W-1:0] w_pset, w_ramp;
  logic [CNT_W:0] w_sub, w_add;
  logic [3:0] w_step_nxt;
  logic w_wrap;
  logic [PHASES*4-1:0] w_vec;
  assign w_pset = periodSet < MINP ? MINP : periodSet;
  assign w_sub = {1'b0, r_period} - {1'b0, periodStep};
  assign w_add = {1'b0, r_period} + {1'b0, periodStep};
  // Simultaneous inc and dec cancel; both directions saturate instead of wrapping.
  assign w_ramp = (freqInc && !freqDec) ? ((w_sub[CNT_W] || w_sub[CNT_W-1:0] < MINP) ? MINP : w_sub[CNT_W-1:0]) :
                  (freqDec && !freqInc) ? (w_add[CNT_W] ? '1 : w_add[CNT_W-1:0]) : r_period;
`ifdef MOTOR_STEP_DIR_REV_EN
  assign w_step_nxt = dirRev ? (r_step0 == 4'd0 ? LAST : r_step0 - 4'd1) : (r_step0 == LAST ? 4'd0 : r_step0 + 4'd1);
  assign w_wrap = dirRev ? r_step0 == 4'd0 : r_step0 == LAST;
`else
  logic w_unused_dir;
  assign w_unused_dir = dirRev;
  assign w_step_nxt = r_step0 == LAST ? 4'd0 : r_step0 + 4'd1;
  assign w_wrap = r_step0 == LAST;
`endif
  always_comb begin
    w_vec = '1;
    for (int k = 0; k < PHASES; k++)
      w_vec[4*k+:4] = r_state == RUN ? (r_step0 >= 4'(k*SEG) ? r_step0 - 4'(k*SEG) : r_step0 + STEPS4 - 4'(k*SEG)) :
                      r_state == STOP ? 4'hE : 4'hF;
  end
  always_ff @(posedge clk) begin
    r_start_d1 <= start;
    if (rst || !start) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_split  <= '0;
      r_step0  <= '0;
      r_round  <= '0;
      r_first  <= 1'b0;
      r_pwm    <= 1'b0;
      r_period <= w_pset;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_period <= w_pset;
          if (!r_start_d1) begin
            r_state <= RUN;
            r_cnt   <= r_period;
            r_split <= splitMax;
            r_step0 <= '0;
            r_first <= 1'b1;
            r_pwm   <= 1'b1;
          end
        end
        RUN: begin
          r_period <= w_ramp;
          if (stopReq) begin
            r_state <= STOP;
            r_first <= 1'b0;
            r_pwm   <= 1'b0;
          end else if (r_cnt <= CNT_W'(1)) begin
            r_cnt   <= r_period;
            r_first <= 1'b1;
            r_split <= r_split == '0 ? splitMax : r_split - SPLIT_W'(1);
            if (r_split == '0) begin
              r_step0 <= w_step_nxt;
              if (w_wrap) r_round <= r_round + ROUND_W'(1);
            end
          end else begin
            r_cnt   <= r_cnt - CNT_W'(1);
            r_first <= 1'b0;
          end
        end
        STOP: r_period <= w_ramp;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign stepVec   = w_vec;
  assign pwmActive = r_pwm;
  assign splitStep = r_split;
  assign cnt       = r_cnt;
  assign cntFirst  = r_first;
  assign cntLast   = r_cnt <= CNT_W'(1);
  assign stepTick  = cntLast && r_split == '0;
  assign periodCur = r_period;
  assign roundCnt  = r_round;
  assign state     = r_state;
endmodule

// File: tb/tb_motor_step_sequencer.sv
// tb_motor_step_sequencer: directed and random checks of the step sequencer against a step-count model.
module tb_motor_step_sequencer;
`ifdef MOTOR_STEP_DIR_REV_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, start, stopReq, dirRev, freqInc, freqDec;
  logic [24:0] periodSet, periodStep;
  logic [1:0] splitMax;
  logic [11:0] stepVec;
  logic pwmActive, cntFirst, cntLast, stepTick;
  logic [1:0] splitStep, state;
  logic [24:0] cnt, periodCur;
  logic [47:0] roundCnt;
  logic [15:0] stepVec4;
  logic unused_pwm, unused_first, unused_last, unused_tick;
  logic [1:0] unused_split, unused_state;
  logic [24:0] unused_cnt, unused_per;
  logic [47:0] unused_round;
  int total = 0, bad = 0;
  int m_st, m_split, m_abs;
  longint m_period, m_len, m_age, m_round;
  bit m_first, m_sd;
  longint c_hold;

  motor_step_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .stopReq(stopReq), .dirRev(dirRev),
    .periodSet(periodSet), .periodStep(periodStep), .splitMax(splitMax),
    .freqInc(freqInc), .freqDec(freqDec), .stepVec(stepVec), .pwmActive(pwmActive),
    .splitStep(splitStep), .cnt(cnt), .cntFirst(cntFirst), .cntLast(cntLast),
    .stepTick(stepTick), .periodCur(periodCur), .roundCnt(roundCnt), .state(state)
  );

  motor_step_sequencer #(.PHASES(4), .STEPS(8)) dut4 (
    .clk(clk), .rst(rst), .start(start), .stopReq(stopReq), .dirRev(dirRev),
    .periodSet(periodSet), .periodStep(periodStep), .splitMax(splitMax),
    .freqInc(freqInc), .freqDec(freqDec), .stepVec(stepVec4), .pwmActive(unused_pwm),
    .splitStep(unused_split), .cnt(unused_cnt), .cntFirst(unused_first), .cntLast(unused_last),
    .stepTick(unused_tick), .periodCur(unused_per), .roundCnt(unused_round), .state(unused_state)
  );

  always #50 clk = ~clk;

  function automatic int md(int a, int s);
    return ((a % s) + s) % s;
  endfunction

  function automatic logic [63:0] evec(int ph, int st);
    logic [63:0] v = '0;
    for (int k = 0; k < ph; k++)
      v[4*k+:4] = m_st == 1 ? 4'(md(m_abs - k * (st / ph), st)) : m_st == 2 ? 4'hE : 4'hF;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    longint pc = periodSet < 25'd2 ? 2 : longint'(periodSet);
    longint rp = m_period;
    int d, o;
    if (freqInc && !freqDec) rp = (m_period - longint'(periodStep) < 2) ? 2 : m_period - longint'(periodStep);
    else if (freqDec && !freqInc) rp = (m_period + longint'(periodStep) > 33554431) ? 33554431 : m_period + longint'(periodStep);
    if (rst || !start) begin
      m_st = 0; m_len = 0; m_age = 0; m_split = 0; m_abs = 0; m_round = 0; m_first = 0; m_period = pc;
    end else if (m_st == 0) begin
      if (!m_sd) begin
        m_st = 1; m_len = m_period; m_age = 0; m_split = int'(splitMax); m_abs = 0; m_round = 0; m_first = 1;
      end
      m_period = pc;
    end else if (m_st == 1 && stopReq) begin
      m_st = 2; m_first = 0; m_period = rp;
    end else if (m_st == 1) begin
      if (m_len - m_age <= 1) begin
        m_len = m_period; m_age = 0; m_first = 1;
        if (m_split == 0) begin
          m_split = int'(splitMax);
          d = (REV && dirRev) ? -1 : 1;
          o = md(m_abs, 12);
          m_abs += d;
          if ((d > 0 && md(m_abs, 12) == 0) || (d < 0 && o == 0)) m_round++;
        end else m_split--;
      end else begin
        m_age++; m_first = 0;
      end
      m_period = rp;
    end else m_period = rp;
    m_sd = start;
  endtask

  task automatic check_all();
    longint ec = m_len - m_age;
    chk("state", state, m_st);
    chk("cnt", cnt, ec);
    chk("splitStep", splitStep, m_split);
    chk("pwmActive", pwmActive, m_st == 1);
    chk("cntFirst", cntFirst, m_first);
    chk("cntLast", cntLast, ec <= 1);
    chk("stepTick", stepTick, ec <= 1 && m_split == 0);
    chk("periodCur", periodCur, m_period);
    chk("roundCnt", roundCnt, m_round);
    chk("stepVec", stepVec, evec(3, 12));
    chk("stepVec4", stepVec4, evec(4, 8));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    rst = 1; start = 0; stopReq = 0; dirRev = 0; freqInc = 0; freqDec = 0;
    periodSet = 25'd4; periodStep = 25'd0; splitMax = 2'd1;
    m_sd = 0; m_st = 0; m_period = 4; m_len = 0; m_age = 0; m_split = 0; m_abs = 0; m_round = 0; m_first = 0;
    #10;
    tick(); tick();
    rst = 0;
    tick();
    chk("rst_state", state, 0);
    chk("rst_vec", stepVec, 12'hFFF);
    chk("rst_period", periodCur, 4);
    start = 1;
    tick();
    chk("run_cnt0", cnt, 4);
    chk("run_vec0", stepVec, 12'h480);
    chk("run_first", cntFirst, 1);
    tick(); chk("run_cnt1", cnt, 3);
    tick(); chk("run_cnt2", cnt, 2);
    tick(); chk("run_cnt3", cnt, 1);
    tick(); chk("run_reload", cnt, 4); chk("run_split0", splitStep, 0);
    tick(); tick(); tick();
    chk("run_vec_hold", stepVec, 12'h480);
    tick();
    chk("run_vec1", stepVec, 12'h591);
    chk("p4_vec1", stepVec4, 16'h3571);
    for (int i = 0; i < 200 && m_abs != 5; i++) tick();
    chk("run_vec5", stepVec, 12'h915);
    for (int i = 0; i < 200 && m_round != 1; i++) tick();
    chk("wrap_round", roundCnt, 1);
    chk("wrap_step", stepVec[3:0], 0);
    dirRev = 1;
    for (int i = 0; i < 20 && stepVec[3:0] == 4'd0; i++) tick();
    chk("dirrev_step", stepVec[3:0], REV ? 4'd11 : 4'd1);
    chk("dirrev_round", roundCnt, REV ? 2 : 1);
    dirRev = 0;
    for (int i = 0; i < 20 && !cntFirst; i++) tick();
    periodStep = 25'd3; freqInc = 1;
    tick();
    freqInc = 0;
    chk("ramp_sat", periodCur, 2);
    chk("ramp_keep3", cnt, 3);
    tick(); chk("ramp_keep2", cnt, 2);
    tick(); chk("ramp_keep1", cnt, 1);
    tick(); chk("ramp_new2", cnt, 2);
    tick(); chk("ramp_new1", cnt, 1);
    tick(); chk("ramp_new_rl", cnt, 2);
    freqInc = 1; freqDec = 1;
    tick();
    chk("ramp_both", periodCur, 2);
    freqInc = 0; periodStep = 25'd2;
    tick();
    freqDec = 0;
    chk("ramp_dec", periodCur, 4);
    for (int i = 0; i < 300 && md(m_abs, 12) != 3; i++) tick();
    stopReq = 1;
    tick();
    stopReq = 0;
    chk("stop_state", state, 2);
    chk("stop_pwm", pwmActive, 0);
    chk("stop_vec", stepVec, 12'hEEE);
    c_hold = m_len - m_age;
    tick(); tick(); tick();
    chk("stop_frozen", cnt, c_hold);
    start = 0;
    tick();
    chk("stop_idle", state, 0);
    chk("stop_idle_vec", stepVec, 12'hFFF);
    start = 1;
    tick();
    chk("restart_state", state, 1);
    chk("restart_vec", stepVec, 12'h480);
    for (int i = 0; i < 13; i++) tick();
    rst = 1;
    tick();
    rst = 0;
    chk("midrst_state", state, 0);
    chk("midrst_cnt", cnt, 0);
    chk("midrst_vec", stepVec, 12'hFFF);
    chk("midrst_pwm", pwmActive, 0);
    start = 0;
    tick();
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom % 600 == 0;
      start = start ? ($urandom % 200 != 0) : ($urandom % 8 == 0);
      stopReq = $urandom % 150 == 0;
      freqInc = $urandom % 15 == 0;
      freqDec = $urandom % 15 == 0;
      if ($urandom % 40 == 0) dirRev = ~dirRev;
      periodStep = 25'($urandom % 4);
      if ($urandom % 100 == 0) periodSet = 25'($urandom_range(0, 6));
      if ($urandom % 300 == 0) splitMax = 2'($urandom % 4);
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
